// File: rtl/fir_mac_engine.sv
// ============================================================================
//  Module      : fir_mac_engine
//  Description : Time-multiplexed FIR multiply-accumulate engine with saturating
//                output register, valid/ready handshake and sticky overrun flag.
//                Macro FIR_MAC_ROUND_EN selects round-half-up on the output shift.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 64,
    parameter int GUARD  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clk_enable,
    input  logic                     tap_valid,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [COEF_W-1:0]        coef_in,
    output logic [$clog2(TAPS)-1:0]  tap_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int ACC_W = DATA_W + COEF_W + GUARD;
    localparam int PRD_W = DATA_W + COEF_W;
    localparam int IDX_W = $clog2(TAPS);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(TAPS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [IDX_W-1:0]          r_tap_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_overrun;

    logic                      w_accept;
    logic                      w_first;
    logic                      w_last;
    logic signed [PRD_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W:0]     w_rnd;
    logic signed [ACC_W:0]     w_shift;
    logic [ACC_W:DATA_W-1]     w_hi;
    logic [DATA_W-1:0]         w_sat;

    assign w_accept = clk_enable & tap_valid;
    assign w_first  = (r_tap_idx == '0);
    assign w_last   = w_accept & (r_tap_idx == c_last_idx);

    assign w_prod     = $signed(data_in) * $signed(coef_in);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_sum      = w_first ? w_prod_ext : (r_acc + w_prod_ext);

    // One extra bit so the rounding constant can never wrap the final sum
`ifdef FIR_MAC_ROUND_EN
    localparam logic signed [ACC_W:0] c_round = (ACC_W+1)'(1) <<< (COEF_W - 2);
    assign w_rnd = {w_sum[ACC_W-1], w_sum} + c_round;
`else
    assign w_rnd = {w_sum[ACC_W-1], w_sum};
`endif

    assign w_shift = w_rnd >>> (COEF_W - 1);
    assign w_hi    = w_shift[ACC_W:DATA_W-1];

    always_comb begin
        w_sat = w_shift[DATA_W-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_sat = w_shift[ACC_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (r_tap_idx == c_last_idx) begin
                w_state_nxt = S_IDLE;
            end else if (w_first) begin
                w_state_nxt = S_ACC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tap_idx <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            r_state   <= w_state_nxt;
            r_acc     <= w_sum;
            r_tap_idx <= (r_tap_idx == c_last_idx) ? '0 : r_tap_idx + 1'b1;
        end
    end

    // A result written on the same edge as a consume keeps out_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overrun   <= 1'b0;
        end else if (clk_enable) begin
            if (w_last) begin
                r_out_data  <= w_sat;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_last && r_out_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign tap_idx   = r_tap_idx;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_engine.sv
// ============================================================================
//  Module      : tb_fir_mac_engine
//  Description : Directed self-checking bench for fir_mac_engine (TAPS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_mac_engine;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 4;
    localparam int GUARD  = 2;

    logic              clk;
    logic              rst_n;
    logic              clk_enable;
    logic              tap_valid;
    logic [DATA_W-1:0] data_in;
    logic [COEF_W-1:0] coef_in;
    logic [1:0]        tap_idx;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              overrun;
    logic              overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    fir_mac_engine #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .GUARD  (GUARD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_enable  (clk_enable),
        .tap_valid   (tap_valid),
        .data_in     (data_in),
        .coef_in     (coef_in),
        .tap_idx     (tap_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Present one accepted tap; returns 1 time unit after the capturing edge
    task automatic tap(input logic [15:0] d, input logic [15:0] c);
        @(negedge clk);
        tap_valid = 1'b1;
        data_in   = d;
        coef_in   = c;
        @(posedge clk);
        #1;
        tap_valid = 1'b0;
    endtask

    task automatic frame4(input logic [15:0] d, input logic [15:0] c);
        for (int i = 0; i < 4; i++) tap(d, c);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_pos_one;
    logic [15:0] exp_neg_one;

    initial begin
`ifdef FIR_MAC_ROUND_EN
        exp_pos_one = 16'h0001;
        exp_neg_one = 16'h0000;
`else
        exp_pos_one = 16'h0000;
        exp_neg_one = 16'hFFFF;
`endif
        rst_n       = 1'b0;
        clk_enable  = 1'b1;
        tap_valid   = 1'b0;
        data_in     = '0;
        coef_in     = '0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_tap_idx",   32'(tap_idx),   32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_overrun",   32'(overrun),   32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4 x (0.5 * 0.25) = 0.5
        tap(16'h4000, 16'h2000);
        tap(16'h4000, 16'h2000);
        check("tap_idx_mid", 32'(tap_idx), 32'h2);
        tap(16'h4000, 16'h2000);
        check("no_valid_early", 32'(out_valid), 32'h0);
        tap(16'h4000, 16'h2000);
        check("half_valid",   32'(out_valid), 32'h1);
        check("half_data",    32'(out_data),  32'h4000);
        check("tap_idx_wrap", 32'(tap_idx),   32'h0);
        idle_cycle();
        check("half_pulse_end", 32'(out_valid), 32'h0);

        // 4 x (0.5 * 0.5) = 1.0, just past full scale
        frame4(16'h4000, 16'h4000);
        check("one_sat_data", 32'(out_data), 32'h7FFF);

        frame4(16'h7FFF, 16'h7FFF);
        check("pos_sat_data", 32'(out_data), 32'h7FFF);
        frame4(16'h8000, 16'h7FFF);
        check("neg_sat_data", 32'(out_data), 32'h8000);
        idle_cycle();
        idle_cycle();
        check("hold_valid", 32'(out_valid), 32'h0);
        check("hold_data",  32'(out_data),  32'h8000);

        tap(16'h0001, 16'h4000);
        tap(16'h0000, 16'h0000);
        tap(16'h0000, 16'h0000);
        tap(16'h0000, 16'h0000);
        check("round_pos", 32'(out_data), 32'(exp_pos_one));
        tap(16'hFFFF, 16'h4000);
        tap(16'h0000, 16'h0000);
        tap(16'h0000, 16'h0000);
        tap(16'h0000, 16'h0000);
        check("round_neg", 32'(out_data), 32'(exp_neg_one));

        // clk_enable low with tap_valid high must freeze everything
        tap(16'h4000, 16'h2000);
        tap(16'h4000, 16'h2000);
        @(negedge clk);
        clk_enable = 1'b0;
        tap_valid  = 1'b1;
        data_in    = 16'h7FFF;
        coef_in    = 16'h7FFF;
        repeat (3) @(posedge clk);
        #1;
        check("en_hold_idx", 32'(tap_idx), 32'h2);
        @(negedge clk);
        tap_valid  = 1'b0;
        clk_enable = 1'b1;
        tap(16'h4000, 16'h2000);
        tap(16'h4000, 16'h2000);
        check("en_resume_data", 32'(out_data), 32'h4000);

        // Overrun: two unconsumed results
        idle_cycle();
        out_ready = 1'b0;
        frame4(16'h4000, 16'h2000);
        check("ovr_first_valid", 32'(out_valid), 32'h1);
        check("ovr_first_flag",  32'(overrun),   32'h0);
        frame4(16'h2000, 16'h2000);
        check("ovr_second_data", 32'(out_data), 32'h2000);
        check("ovr_second_flag", 32'(overrun),  32'h1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_cleared",   32'(overrun),   32'h0);
        check("ovr_valid_kept", 32'(out_valid), 32'h1);
        frame4(16'h4000, 16'h2000);
        check("ovr_set_wins", 32'(overrun), 32'h1);
        @(negedge clk);
        overrun_clr = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_consumed", 32'(out_valid), 32'h0);
        check("ovr_sticky",   32'(overrun),   32'h1);

        // Reset mid-frame discards the partial sum
        tap(16'h7FFF, 16'h7FFF);
        tap(16'h7FFF, 16'h7FFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_tap_idx", 32'(tap_idx), 32'h0);
        check("arst_overrun", 32'(overrun), 32'h0);
        check("arst_data",    32'(out_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        frame4(16'h4000, 16'h2000);
        check("post_rst_data", 32'(out_data), 32'h4000);

        // Gaps inside a frame
        idle_cycle();
        tap(16'h4000, 16'h2000);
        idle_cycle();
        tap(16'h4000, 16'h2000);
        idle_cycle();
        idle_cycle();
        check("gap_idx_hold", 32'(tap_idx),   32'h2);
        check("gap_no_valid", 32'(out_valid), 32'h0);
        tap(16'h4000, 16'h2000);
        idle_cycle();
        tap(16'h4000, 16'h2000);
        check("gap_data",  32'(out_data),  32'h4000);
        check("gap_valid", 32'(out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
